// File: rtl/serial_uint_sub.sv
// rtl/serial_uint_sub.sv - multi-cycle unsigned subtractor, chunk bits per cycle, LSB first
// O = (I0 - I1) mod 2^width; O_borrow is the unsigned less-than flag.

module serial_uint_sub #(
   parameter int width = 8,
   parameter int chunk = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [width-1:0] I0,
   input  logic [width-1:0] I1,
   input  logic             I_valid,
   output logic             I_ready,
   output logic [width-1:0] O,
   output logic             O_borrow,
   output logic             O_valid,
   input  logic             O_ready
);

   localparam int N  = width / chunk;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (width < 1 || chunk < 1 || (width % chunk) != 0) begin : g_bad_params
      $error("serial_uint_sub: chunk must divide width exactly");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic             borrow;
   logic [width-1:0] a_reg;
   logic [width-1:0] s_reg;
   logic [width-1:0] res_reg;
   logic [width-1:0] o_reg;
   logic             o_borrow_reg;

   logic [chunk:0]   step;
   logic [width-1:0] res_next;
   logic             last;

   // One extra bit on the chunk difference makes its top bit the borrow out.
   always_comb begin
      step     = {1'b0, a_reg[chunk-1:0]} - {1'b0, s_reg[chunk-1:0]} - {{chunk{1'b0}}, borrow};
      res_next = res_reg >> chunk;
      res_next[width-1 -: chunk] = step[chunk-1:0];
   end

   assign last = (count == CW'(N - 1));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         count        <= '0;
         borrow       <= 1'b0;
         a_reg        <= '0;
         s_reg        <= '0;
         res_reg      <= '0;
         o_reg        <= '0;
         o_borrow_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (I_valid) begin
                  a_reg   <= I0;
                  s_reg   <= I1;
                  res_reg <= '0;
                  borrow  <= 1'b0;
                  count   <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               borrow  <= step[chunk];
               a_reg   <= a_reg >> chunk;
               s_reg   <= s_reg >> chunk;
               res_reg <= res_next;
               count   <= count + 1'b1;
               // Output copies keep the previous result visible until this one completes.
               if (last) begin
                  o_reg        <= res_next;
                  o_borrow_reg <= step[chunk];
                  state        <= DONE;
               end
            end
            DONE: begin
               if (O_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign I_ready  = (state == IDLE);
   assign O_valid  = (state == DONE);
   assign O        = o_reg;
   assign O_borrow = o_borrow_reg;

endmodule
